// File: rtl/phase_sequencer.sv
// Run/stall/halt phase controller for a multi-cycle CPU: one-hot phase, memory stalls,
// boundary-only halts and a retired-instruction counter. Single-step is built when PHASE_STEP_EN is defined.
module phase_sequencer #(
    parameter int NUM_PHASES  = 4,
    parameter int WAIT_PHASE  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   mem_wait,
`ifdef PHASE_STEP_EN
    input  logic                   step_mode,
    input  logic                   step,
`endif
    output logic [NUM_PHASES-1:0]  phase,
    output logic [2:0]             phase_idx,
    output logic                   running,
    output logic                   stalled,
    output logic                   halted,
    output logic                   retire,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_HALTED
    } state_e;

    localparam logic [2:0]            LAST_IDX  = 3'(NUM_PHASES - 1);
    localparam logic [2:0]            WAIT_IDX  = 3'(WAIT_PHASE);
    localparam logic [NUM_PHASES-1:0] PHASE_ONE = NUM_PHASES'(1);

    state_e                  state_q, state_d;
    logic [2:0]              phase_idx_q, phase_idx_d;
    logic [NUM_PHASES-1:0]   phase_q, phase_d;
    logic                    running_q, running_d;
    logic                    stalled_q, stalled_d;
    logic                    halted_q, halted_d;
    logic                    retire_q, retire_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    advance;
    logic                    halt_now;
    logic                    resume;

`ifdef PHASE_STEP_EN
    assign halt_now = halt_req | step_mode;
    assign resume   = start | step;
`else
    assign halt_now = halt_req;
    assign resume   = start;
`endif

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        retire_d    = 1'b0;
        count_d     = count_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    phase_idx_d = 3'd0;
                end
            end
            S_RUN: begin
                if (phase_idx_q == WAIT_IDX && mem_wait) begin
                    state_d = S_STALL;
                end else begin
                    advance = 1'b1;
                end
            end
            S_STALL: begin
                // Release advances on the same edge, so stall length equals mem_wait-high cycles.
                if (!mem_wait) begin
                    state_d = S_RUN;
                    advance = 1'b1;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    state_d     = S_RUN;
                    phase_idx_d = 3'd0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                phase_idx_d = 3'd0;
            end
        endcase

        if (advance) begin
            if (phase_idx_q == LAST_IDX) begin
                phase_idx_d = 3'd0;
                retire_d    = 1'b1;
                count_d     = count_q + COUNT_WIDTH'(1);
                state_d     = halt_now ? S_HALTED : S_RUN;
            end else begin
                phase_idx_d = phase_idx_q + 3'd1;
            end
        end

        running_d = (state_d == S_RUN) || (state_d == S_STALL);
        stalled_d = (state_d == S_STALL);
        halted_d  = (state_d == S_HALTED);
        phase_d   = running_d ? (PHASE_ONE << phase_idx_d) : '0;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q     <= S_IDLE;
            phase_idx_q <= 3'd0;
            phase_q     <= '0;
            running_q   <= 1'b0;
            stalled_q   <= 1'b0;
            halted_q    <= 1'b0;
            retire_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_idx_q <= phase_idx_d;
            phase_q     <= phase_d;
            running_q   <= running_d;
            stalled_q   <= stalled_d;
            halted_q    <= halted_d;
            retire_q    <= retire_d;
            count_q     <= count_d;
        end
    end

    assign phase       = phase_q;
    assign phase_idx   = phase_idx_q;
    assign running     = running_q;
    assign stalled     = stalled_q;
    assign halted      = halted_q;
    assign retire      = retire_q;
    assign instr_count = count_q;

endmodule
